// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select (step, redirect, exception, eret), held redirect, EPC capture.
// Latency: every PC/EPC change is visible one cycle after the qualifying clock edge.
// Backpressure: enable=0 stalls the PC; a redirect seen during a stall is held until enable returns.
module pc_unit #(
  parameter int              N_BITS     = 32,
  parameter logic [N_BITS-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [N_BITS-1:0] EXC_VECTOR = 32'h8000_0180,
  parameter int              PC_STEP    = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              redirect_i,
  input  logic [N_BITS-1:0] redirect_target_i,
  input  logic              exc_i,
  input  logic [N_BITS-1:0] epc_src_i,
  input  logic              eret_i,
  output logic [N_BITS-1:0] pc_value_o,
  output logic [N_BITS-1:0] pc_next_seq_o,
  output logic [N_BITS-1:0] epc_o,
  output logic              redirect_pending_o,
  output logic              misaligned_o
);

  // Mask that clears the low ALIGN_BITS of a loaded target.
  localparam logic [N_BITS-1:0] ALIGN_MASK = ~((N_BITS'(1) << ALIGN_BITS) - N_BITS'(1));

  // RUN: no held redirect. HOLD: a redirect arrived during a stall and waits in pend_tgt.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [N_BITS-1:0] pc, pc_d;
  logic [N_BITS-1:0] epc, epc_d;
  logic [N_BITS-1:0] pend_tgt, pend_tgt_d;
  logic              mis, mis_d;
  logic [N_BITS-1:0] seq_pc;
  logic [N_BITS-1:0] load_tgt;
  logic              load_en;

  assign seq_pc = pc + N_BITS'(PC_STEP);

  // Next-state and datapath select, in strict priority order.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    epc_d      = epc;
    pend_tgt_d = pend_tgt;
    load_tgt   = '0;
    load_en    = 1'b0;

    if (exc_i) begin
      // Exception vector is a fixed aligned address; never flagged misaligned.
      pc_d    = EXC_VECTOR;
      epc_d   = epc_src_i;
      state_d = RUN;
    end else if (eret_i) begin
      load_tgt = epc;
      load_en  = 1'b1;
      state_d  = RUN;
    end else if (enable && redirect_i) begin
      // A fresh redirect supersedes whatever was being held.
      load_tgt = redirect_target_i;
      load_en  = 1'b1;
      state_d  = RUN;
    end else if (enable && (state == HOLD)) begin
      load_tgt = pend_tgt;
      load_en  = 1'b1;
      state_d  = RUN;
    end else if (enable) begin
      pc_d = seq_pc;
    end else if (redirect_i) begin
      // Stalled redirect: newest target wins while the stall lasts.
      pend_tgt_d = redirect_target_i;
      state_d    = HOLD;
    end

    if (load_en) begin
      pc_d = load_tgt & ALIGN_MASK;
    end
    mis_d = load_en && ((load_tgt & ~ALIGN_MASK) != '0);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      epc      <= '0;
      pend_tgt <= '0;
      mis      <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      epc      <= epc_d;
      pend_tgt <= pend_tgt_d;
      mis      <= mis_d;
    end
  end

  assign pc_value_o         = pc;
  assign pc_next_seq_o      = seq_pc;
  assign epc_o              = epc;
  assign redirect_pending_o = (state == HOLD);
  assign misaligned_o       = mis;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, stepping, held redirects, exceptions, alignment, wrap, priorities.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Each scenario task carries its own expected values.
module tb_pc_unit;
  logic        clk;
  logic        reset;
  logic        enable;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        exc_i;
  logic [31:0] epc_src_i;
  logic        eret_i;
  logic [31:0] pc_value_o;
  logic [31:0] pc_next_seq_o;
  logic [31:0] epc_o;
  logic        redirect_pending_o;
  logic        misaligned_o;

  int checks = 0;
  int passes = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .enable(enable),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .exc_i(exc_i), .epc_src_i(epc_src_i), .eret_i(eret_i),
    .pc_value_o(pc_value_o), .pc_next_seq_o(pc_next_seq_o), .epc_o(epc_o),
    .redirect_pending_o(redirect_pending_o), .misaligned_o(misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
    exc_i = 1'b0; epc_src_i = '0; eret_i = 1'b0;
    step(); step();
    checks++; if (pc_value_o !== 32'h0040_0000) $display("FAIL reset_pc got %h want %h", pc_value_o, 32'h0040_0000); else passes++;
    checks++; if (epc_o !== 32'h0) $display("FAIL reset_epc got %h want 0", epc_o); else passes++;
    checks++; if (redirect_pending_o !== 1'b0) $display("FAIL reset_pend got %b want 0", redirect_pending_o); else passes++;
    checks++; if (misaligned_o !== 1'b0) $display("FAIL reset_mis got %b want 0", misaligned_o); else passes++;
    checks++; if (pc_next_seq_o !== 32'h0040_0004) $display("FAIL reset_nseq got %h want %h", pc_next_seq_o, 32'h0040_0004); else passes++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
    reset = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_value_o !== exp_pc[i]) $display("FAIL seq_pc[%0d] got %h want %h", i, pc_value_o, exp_pc[i]); else passes++;
    end
    checks++; if (epc_o !== 32'h0) $display("FAIL seq_epc got %h want 0", epc_o); else passes++;
    checks++; if (redirect_pending_o !== 1'b0) $display("FAIL seq_pend got %b want 0", redirect_pending_o); else passes++;
    checks++; if (misaligned_o !== 1'b0) $display("FAIL seq_mis got %b want 0", misaligned_o); else passes++;
  endtask

  task automatic test_stall_redirect();
    enable = 1'b0; redirect_i = 1'b1; redirect_target_i = 32'h0040_0100;
    step();
    checks++; if (pc_value_o !== 32'h0040_000C) $display("FAIL stall1_pc got %h want %h", pc_value_o, 32'h0040_000C); else passes++;
    checks++; if (redirect_pending_o !== 1'b1) $display("FAIL stall1_pend got %b want 1", redirect_pending_o); else passes++;
    redirect_target_i = 32'h0040_0200;
    step();
    checks++; if (pc_value_o !== 32'h0040_000C) $display("FAIL stall2_pc got %h want %h", pc_value_o, 32'h0040_000C); else passes++;
    checks++; if (redirect_pending_o !== 1'b1) $display("FAIL stall2_pend got %b want 1", redirect_pending_o); else passes++;
    redirect_i = 1'b0; enable = 1'b1;
    step();
    checks++; if (pc_value_o !== 32'h0040_0200) $display("FAIL release_pc got %h want %h", pc_value_o, 32'h0040_0200); else passes++;
    checks++; if (redirect_pending_o !== 1'b0) $display("FAIL release_pend got %b want 0", redirect_pending_o); else passes++;
    checks++; if (misaligned_o !== 1'b0) $display("FAIL release_mis got %b want 0", misaligned_o); else passes++;
    step();
    checks++; if (pc_value_o !== 32'h0040_0204) $display("FAIL after_release_pc got %h want %h", pc_value_o, 32'h0040_0204); else passes++;
  endtask

  task automatic test_exception();
    enable = 1'b0; redirect_i = 1'b1; redirect_target_i = 32'h0040_0300;
    step();
    checks++; if (redirect_pending_o !== 1'b1) $display("FAIL exc_pre_pend got %b want 1", redirect_pending_o); else passes++;
    redirect_i = 1'b0; exc_i = 1'b1; epc_src_i = 32'h0040_0010;
    step();
    checks++; if (pc_value_o !== 32'h8000_0180) $display("FAIL exc_pc got %h want %h", pc_value_o, 32'h8000_0180); else passes++;
    checks++; if (epc_o !== 32'h0040_0010) $display("FAIL exc_epc got %h want %h", epc_o, 32'h0040_0010); else passes++;
    checks++; if (redirect_pending_o !== 1'b0) $display("FAIL exc_pend got %b want 0", redirect_pending_o); else passes++;
    exc_i = 1'b0; eret_i = 1'b1;
    step();
    checks++; if (pc_value_o !== 32'h0040_0010) $display("FAIL eret_pc got %h want %h", pc_value_o, 32'h0040_0010); else passes++;
    checks++; if (epc_o !== 32'h0040_0010) $display("FAIL eret_epc got %h want %h", epc_o, 32'h0040_0010); else passes++;
    eret_i = 1'b0;
    step();
    checks++; if (pc_value_o !== 32'h0040_0010) $display("FAIL stall_hold_pc got %h want %h", pc_value_o, 32'h0040_0010); else passes++;
  endtask

  task automatic test_misaligned();
    enable = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h0040_0103;
    step();
    checks++; if (pc_value_o !== 32'h0040_0100) $display("FAIL mis_pc got %h want %h", pc_value_o, 32'h0040_0100); else passes++;
    checks++; if (misaligned_o !== 1'b1) $display("FAIL mis_pulse got %b want 1", misaligned_o); else passes++;
    redirect_i = 1'b0;
    step();
    checks++; if (pc_value_o !== 32'h0040_0104) $display("FAIL mis_step_pc got %h want %h", pc_value_o, 32'h0040_0104); else passes++;
    checks++; if (misaligned_o !== 1'b0) $display("FAIL mis_clear got %b want 0", misaligned_o); else passes++;
    // Misaligned held redirect: flag appears only when it is applied.
    enable = 1'b0; redirect_i = 1'b1; redirect_target_i = 32'h0040_0207;
    step();
    checks++; if (misaligned_o !== 1'b0) $display("FAIL mis_held_early got %b want 0", misaligned_o); else passes++;
    redirect_i = 1'b0; enable = 1'b1;
    step();
    checks++; if (pc_value_o !== 32'h0040_0204) $display("FAIL mis_held_pc got %h want %h", pc_value_o, 32'h0040_0204); else passes++;
    checks++; if (misaligned_o !== 1'b1) $display("FAIL mis_held_pulse got %b want 1", misaligned_o); else passes++;
    // Misaligned EPC returned through eret.
    exc_i = 1'b1; epc_src_i = 32'h0040_0012;
    step();
    checks++; if (misaligned_o !== 1'b0) $display("FAIL mis_exc got %b want 0", misaligned_o); else passes++;
    exc_i = 1'b0; eret_i = 1'b1;
    step();
    checks++; if (pc_value_o !== 32'h0040_0010) $display("FAIL mis_eret_pc got %h want %h", pc_value_o, 32'h0040_0010); else passes++;
    checks++; if (misaligned_o !== 1'b1) $display("FAIL mis_eret_pulse got %b want 1", misaligned_o); else passes++;
    eret_i = 1'b0;
  endtask

  task automatic test_wrap_priority();
    enable = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    step();
    checks++; if (pc_value_o !== 32'hFFFF_FFFC) $display("FAIL wrap_top_pc got %h want %h", pc_value_o, 32'hFFFF_FFFC); else passes++;
    checks++; if (pc_next_seq_o !== 32'h0) $display("FAIL wrap_nseq got %h want 0", pc_next_seq_o); else passes++;
    redirect_i = 1'b0;
    step();
    checks++; if (pc_value_o !== 32'h0) $display("FAIL wrap_pc got %h want 0", pc_value_o); else passes++;
    checks++; if (misaligned_o !== 1'b0) $display("FAIL wrap_mis got %b want 0", misaligned_o); else passes++;
    // exc + eret + redirect together: exception wins.
    exc_i = 1'b1; eret_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h0040_0400; epc_src_i = 32'h0000_0040;
    step();
    checks++; if (pc_value_o !== 32'h8000_0180) $display("FAIL exc_eret_pc got %h want %h", pc_value_o, 32'h8000_0180); else passes++;
    checks++; if (epc_o !== 32'h0000_0040) $display("FAIL exc_eret_epc got %h want %h", epc_o, 32'h0000_0040); else passes++;
    // eret + redirect: eret wins.
    exc_i = 1'b0;
    step();
    checks++; if (pc_value_o !== 32'h0000_0040) $display("FAIL eret_redir_pc got %h want %h", pc_value_o, 32'h0000_0040); else passes++;
    eret_i = 1'b0; redirect_i = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    enable = 1'b0; redirect_i = 1'b1; redirect_target_i = 32'h0040_0500;
    step();
    checks++; if (redirect_pending_o !== 1'b1) $display("FAIL rst_pre_pend got %b want 1", redirect_pending_o); else passes++;
    redirect_i = 1'b0; reset = 1'b0;
    #3;
    checks++; if (pc_value_o !== 32'h0000_0040) $display("FAIL rst_between_pc got %h want %h", pc_value_o, 32'h0000_0040); else passes++;
    checks++; if (redirect_pending_o !== 1'b1) $display("FAIL rst_between_pend got %b want 1", redirect_pending_o); else passes++;
    step();
    checks++; if (pc_value_o !== 32'h0040_0000) $display("FAIL rst_pc got %h want %h", pc_value_o, 32'h0040_0000); else passes++;
    checks++; if (redirect_pending_o !== 1'b0) $display("FAIL rst_pend got %b want 0", redirect_pending_o); else passes++;
    checks++; if (epc_o !== 32'h0) $display("FAIL rst_epc got %h want 0", epc_o); else passes++;
    reset = 1'b1;
    #3;
    checks++; if (pc_value_o !== 32'h0040_0000) $display("FAIL rst_deassert_pc got %h want %h", pc_value_o, 32'h0040_0000); else passes++;
    enable = 1'b1;
    step();
    checks++; if (pc_value_o !== 32'h0040_0004) $display("FAIL rst_resume_pc got %h want %h", pc_value_o, 32'h0040_0004); else passes++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_exception();
    test_misaligned();
    test_wrap_priority();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
